// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the single-ported data memory.
// Each access is latched in IDLE, issued for one cycle, then waits out the read latency.
module dm_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic [3:0]        byteen0,
  output logic              done0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        byteen1,
  output logic              done1,
  output logic [31:0]       rdata1,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byteen,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nxt;
  logic              last;
  logic              gnt;
  logic              sel_p0;
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic [3:0]        byteen_p0;
  logic [2:0]        cnt_p0;
  logic              done_s;
  logic [31:0]       rdata_s;

  // On a tie the master that did not win last time is granted.
  assign gnt = (req0 && req1) ? ~last : req1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel_p0    <= 1'b0;
      we_p0     <= 1'b0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      byteen_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel_p0    <= gnt;
            last      <= gnt;
            we_p0     <= gnt ? we1 : we0;
            addr_p0   <= gnt ? addr1 : addr0;
            wdata_p0  <= gnt ? wdata1 : wdata0;
            byteen_p0 <= gnt ? byteen1 : byteen0;
          end
        end
        ISSUE: begin
          if (!we_p0) cnt_p0 <= 3'(MEM_LAT);
        end
        WAIT: cnt_p0 <= cnt_p0 - 3'd1;
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  // Memory-side outputs are only driven from the latched access, and only in ISSUE.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    done_s     = 1'b0;
    rdata_s    = '0;
    case (state)
      IDLE: begin
        if (req0 || req1) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy       = 1'b1;
        mem_en     = !we_p0 || (byteen_p0 != 4'b0000);
        mem_we     = we_p0;
        mem_addr   = addr_p0 & {{(ADDR_W-2){1'b1}}, 2'b00};
        mem_wdata  = wdata_p0;
        mem_byteen = we_p0 ? byteen_p0 : 4'b0000;
        if (we_p0) begin
          done_s    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt_p0 == 3'd1) begin
          done_s    = 1'b1;
          rdata_s   = mem_rdata;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done0  = done_s & ~sel_p0;
  assign done1  = done_s & sel_p0;
  assign rdata0 = sel_p0 ? 32'h0 : rdata_s;
  assign rdata1 = sel_p0 ? rdata_s : 32'h0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: instance A uses MEM_LAT=2, instance B uses MEM_LAT=3
// and shares A's field inputs but has its own request and reset lines.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset, reset_b, mem_clr;
  logic        req0, req1, req0_b, req1_b;
  logic        we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic [3:0]  byteen0, byteen1;

  logic        done0_a, done1_a, busy_a, mem_en_a, mem_we_a;
  logic [31:0] rdata0_a, rdata1_a, mem_addr_a, mem_wdata_a;
  logic [3:0]  mem_byteen_a;
  logic        done0_b, done1_b, busy_b, mem_en_b, mem_we_b;
  logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_byteen_b;

  logic [31:0] mem [16];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_LAT(2), .ADDR_W(32)) u_a (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .byteen0(byteen0),
    .done0(done0_a), .rdata0(rdata0_a),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .byteen1(byteen1),
    .done1(done1_a), .rdata1(rdata1_a),
    .busy(busy_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_byteen(mem_byteen_a), .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.MEM_LAT(3), .ADDR_W(32)) u_b (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .we0(we0), .addr0(addr0), .wdata0(wdata0), .byteen0(byteen0),
    .done0(done0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(we1), .addr1(addr1), .wdata1(wdata1), .byteen1(byteen1),
    .done1(done1_b), .rdata1(rdata1_b),
    .busy(busy_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_byteen(mem_byteen_b), .mem_rdata(mem_rdata)
  );

  // Byte-lane memory model attached to instance A.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (mem_en_a && mem_we_a) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen_a[b]) mem[mem_addr_a[5:2]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1; mem_clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    byteen0 = '0; byteen1 = '0; mem_rdata = '0;
    tick; tick;
    reset = 1'b0; reset_b = 1'b0; mem_clr = 1'b0;

    // Reset state
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_mem_en", mem_en_a, 1'b0);
    chk1("rst_mem_we", mem_we_a, 1'b0);
    chk1("rst_done0", done0_a, 1'b0);
    chk1("rst_done1", done1_a, 1'b0);
    chk32("rst_mem_addr", mem_addr_a, 32'h0);
    chk32("rst_rdata0", rdata0_a, 32'h0);
    chk32("rst_rdata1", rdata1_a, 32'h0);

    // Single write from master 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_1006; wdata0 = 32'h5A5A_5A5A; byteen0 = 4'b0100;
    tick;
    req0 = 1'b0;
    chk1("w0_mem_en", mem_en_a, 1'b1);
    chk1("w0_mem_we", mem_we_a, 1'b1);
    chk32("w0_mem_addr", mem_addr_a, 32'h0000_1004);
    chk32("w0_mem_wdata", mem_wdata_a, 32'h5A5A_5A5A);
    chk32("w0_mem_byteen", 32'(mem_byteen_a), 32'h4);
    chk1("w0_done0", done0_a, 1'b1);
    chk1("w0_done1", done1_a, 1'b0);
    chk1("w0_busy", busy_a, 1'b1);
    tick;
    chk1("w0_idle_busy", busy_a, 1'b0);
    chk1("w0_idle_done0", done0_a, 1'b0);
    chk1("w0_idle_mem_en", mem_en_a, 1'b0);
    chk32("w0_mem_word", mem[1], 32'h005A_0000);

    // Single read from master 1, MEM_LAT=2
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; byteen1 = 4'hF;
    tick;
    req1 = 1'b0;
    chk1("r1_mem_en", mem_en_a, 1'b1);
    chk1("r1_mem_we", mem_we_a, 1'b0);
    chk32("r1_mem_addr", mem_addr_a, 32'h10);
    chk32("r1_mem_byteen", 32'(mem_byteen_a), 32'h0);
    chk1("r1_busy_n1", busy_a, 1'b1);
    chk1("r1_done1_n1", done1_a, 1'b0);
    tick;
    mem_rdata = 32'hDEAD_BEEF;
    chk1("r1_busy_n2", busy_a, 1'b1);
    chk1("r1_mem_en_n2", mem_en_a, 1'b0);
    chk1("r1_done1_n2", done1_a, 1'b0);
    chk32("r1_rdata1_n2", rdata1_a, 32'h0);
    tick;
    chk1("r1_busy_n3", busy_a, 1'b1);
    chk1("r1_done1_n3", done1_a, 1'b1);
    chk1("r1_done0_n3", done0_a, 1'b0);
    chk32("r1_rdata1_n3", rdata1_a, 32'hDEAD_BEEF);
    chk32("r1_rdata0_n3", rdata0_a, 32'h0);
    tick;
    mem_rdata = 32'h0;
    chk1("r1_busy_n4", busy_a, 1'b0);
    chk1("r1_done1_n4", done1_a, 1'b0);

    // Contention from reset: grants alternate 0,1,0,1,...
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    byteen0 = 4'hF; byteen1 = 4'hF; addr0 = 32'h40; addr1 = 32'h80;
    for (int i = 0; i < 8; i++) begin
      wdata0 = 32'h1000_0000 + 32'(i);
      wdata1 = 32'h2000_0000 + 32'(i);
      chk1("cn_idle_busy", busy_a, 1'b0);
      tick;
      chk1("cn_done0", done0_a, (i % 2) == 0);
      chk1("cn_done1", done1_a, (i % 2) == 1);
      chk32("cn_mem_addr", mem_addr_a, ((i % 2) == 1) ? 32'h80 : 32'h40);
      chk32("cn_mem_wdata", mem_wdata_a, ((i % 2) == 1) ? wdata1 : wdata0);
      tick;
      req0 = (i % 2) == 1;
      req1 = (i % 2) == 0;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;

    // Zero-byteen write is a no-op on memory but still completes
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_1006; wdata0 = 32'hFFFF_FFFF; byteen0 = 4'b0000;
    chk1("zb_mem_en_idle", mem_en_a, 1'b0);
    tick;
    req0 = 1'b0;
    chk1("zb_mem_en", mem_en_a, 1'b0);
    chk1("zb_done0", done0_a, 1'b1);
    chk1("zb_busy", busy_a, 1'b1);
    tick;
    chk1("zb_mem_en_after", mem_en_a, 1'b0);
    chk1("zb_done0_after", done0_a, 1'b0);
    chk32("zb_mem_word", mem[1], 32'h005A_0000);

    // Field changes after latch are ignored (write, then read)
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h08; wdata0 = 32'h1122_3344; byteen0 = 4'hF;
    tick;
    req0 = 1'b0; addr0 = 32'h3C; wdata0 = 32'hAAAA_AAAA; byteen0 = 4'h1;
    chk32("fc_w_mem_addr", mem_addr_a, 32'h08);
    chk32("fc_w_mem_wdata", mem_wdata_a, 32'h1122_3344);
    chk32("fc_w_mem_byteen", 32'(mem_byteen_a), 32'hF);
    tick;
    chk32("fc_w_mem_word", mem[2], 32'h1122_3344);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0C;
    tick;
    req0 = 1'b0; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h55;
    chk32("fc_r_mem_addr", mem_addr_a, 32'h0C);
    chk1("fc_r_mem_we", mem_we_a, 1'b0);
    tick;
    addr0 = 32'h34; wdata0 = 32'h66; mem_rdata = 32'h600D_F00D;
    chk1("fc_r_wait_mem_en", mem_en_a, 1'b0);
    chk1("fc_r_wait_done0", done0_a, 1'b0);
    tick;
    chk1("fc_r_done0", done0_a, 1'b1);
    chk32("fc_r_rdata0", rdata0_a, 32'h600D_F00D);
    chk1("fc_r_mem_en", mem_en_a, 1'b0);
    tick;
    mem_rdata = 32'h0;
    chk1("fc_r_busy_after", busy_a, 1'b0);

    // Instance B (MEM_LAT=3): reset during WAIT of a master-0 read
    req0_b = 1'b1; we0 = 1'b0; addr0 = 32'h44;
    tick;
    req0_b = 1'b0;
    chk1("rw_mem_en", mem_en_b, 1'b1);
    chk32("rw_mem_addr", mem_addr_b, 32'h44);
    chk32("rw_mem_byteen", 32'(mem_byteen_b), 32'h0);
    tick;
    chk1("rw_wait_busy", busy_b, 1'b1);
    chk1("rw_wait_done0", done0_b, 1'b0);
    reset_b = 1'b1; mem_rdata = 32'hCAFE_F00D;
    req0_b = 1'b1; req1_b = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 32'h50; addr1 = 32'h60; wdata0 = 32'h0A0A_0A0A; wdata1 = 32'h0B0B_0B0B;
    byteen0 = 4'hF; byteen1 = 4'hF;
    tick;
    reset_b = 1'b0;
    chk1("rw_rst_busy", busy_b, 1'b0);
    chk1("rw_rst_mem_en", mem_en_b, 1'b0);
    chk1("rw_rst_mem_we", mem_we_b, 1'b0);
    chk1("rw_rst_done0", done0_b, 1'b0);
    chk1("rw_rst_done1", done1_b, 1'b0);
    chk32("rw_rst_rdata0", rdata0_b, 32'h0);
    chk32("rw_rst_rdata1", rdata1_b, 32'h0);
    chk32("rw_rst_mem_addr", mem_addr_b, 32'h0);
    chk32("rw_rst_mem_wdata", mem_wdata_b, 32'h0);
    chk32("rw_rst_mem_byteen", 32'(mem_byteen_b), 32'h0);
    tick;
    req0_b = 1'b0;
    chk1("rw_tie_done0", done0_b, 1'b1);
    chk1("rw_tie_done1", done1_b, 1'b0);
    chk32("rw_tie_mem_addr", mem_addr_b, 32'h50);
    tick;
    chk1("rw_next_done", done0_b | done1_b, 1'b0);
    tick;
    req1_b = 1'b0;
    chk1("rw_m1_done1", done1_b, 1'b1);
    chk32("rw_m1_mem_addr", mem_addr_b, 32'h60);
    tick;
    chk1("rw_end_busy", busy_b, 1'b0);
    mem_rdata = 32'h0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter and access sequencer for the single-ported data memory.
- Master 0 is the CPU M-stage load/store port. Its byte enables are already formed by the store byte-enable logic.
- Master 1 is a secondary bus master, such as the bridge/DMA port.
- Sequences one access at a time: latch, issue, wait read latency, respond. Uses round-robin priority and provides a per-master done pulse, which the CPU uses for stall release.

Parameters:
MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal 1..4
ADDR_W, 32, address width

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
req0  input  1  master 0 request; held with fields stable until done0
we0  input  1  master 0 write (1) / read (0)
addr0  input  ADDR_W  master 0 byte address
wdata0  input  32  master 0 write data (already lane-replicated)
byteen0  input  4  master 0 write byte enables
done0  output  1  master 0 access complete (1-cycle pulse)
rdata0  output  32  master 0 read data, valid when done0 on a read
req1, we1, addr1, wdata1, byteen1, done1, rdata1: same as master 0, for master 1
busy  output  1  arbiter not in IDLE
mem_en  output  1  memory access strobe
mem_we  output  1  memory write
mem_addr  output  ADDR_W  word address, {addr[ADDR_W-1:2],2'b00}
mem_wdata  output  32  memory write data
mem_byteen  output  4  memory byte enables; 4'b0000 on reads
mem_rdata  input  32  memory read data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, last=1 (master 0 wins first tie), all outputs 0, latched fields 0, counter 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high, select the winner. When both are high, the winner is the master != last.
  - On the edge, latch sel, we, addr, wdata and byteen; set last=sel; go to ISSUE.
  - If no req, stay in IDLE.
- ISSUE (one cycle):
  - Drive mem_en=1, mem_we=we_l, mem_addr=word-aligned addr_l, mem_wdata=wdata_l.
  - mem_byteen is byteen_l for writes and 0 for reads.
  - Write: done_sel=1 this cycle; next state IDLE.
  - Write with byteen_l=4'b0000: mem_en=0 (no-op), but done_sel still pulses; next state IDLE.
  - Read: load counter=MEM_LAT; go to WAIT.
- WAIT:
  - mem_en=0; decrement counter each cycle.
  - In the cycle the counter reaches 1: done_sel=1, rdata_sel=mem_rdata (combinational pass-through); next state IDLE.
  - rdata of the non-selected master is 0.
- Latency from req sampled in IDLE at cycle N:
  - Write: done in N+1.
  - Read: done in N+1+MEM_LAT.
- Throughput: IDLE is mandatory between accesses. The minimum spacing is 2 cycles per write and 2+MEM_LAT cycles per read.
- A req still high in the cycle after done is a new request. Masters must drop req in the cycle following done.
- Changes to req/fields while not in IDLE are ignored; only latched values drive memory.
- Simultaneous req0 and req1 in IDLE: the master not granted last time wins. Under constant contention this strictly alternates 0,1,0,1.
- busy=1 in ISSUE and WAIT.
- No done is ever asserted to both masters in one cycle.
- Reset mid-access (ISSUE or WAIT): abandon immediately; no done is issued and mem_en=0 in the following cycle.
- addr bits [1:0] do not reach the memory; lane selection is carried only by byteen.

Test Plan:
- Single write from master 0: addr0=0x0000_1006, wdata0=0x5A5A5A5A, byteen0=4'b0100. Expect mem_en=1, mem_addr=0x0000_1004, mem_byteen=4'b0100 one cycle after req, with done0 in the same cycle.
- Single read from master 1, MEM_LAT=2: addr1=0x10, memory returns 0xDEADBEEF. Expect mem_en with mem_byteen=0 at cycle N+1, then done1 and rdata1=0xDEADBEEF at N+3, with busy high N+1..N+3.
- Contention: req0 and req1 held continuously for four writes each (each master drops req for one cycle after its done). Expect a grant order of 0,1,0,1,… starting with master 0 after reset, and never both done signals in the same cycle.
- Zero-byteen write: we0=1, byteen0=0. Expect done0 to pulse, mem_en=0 throughout, and memory contents unchanged.
- Reset asserted during WAIT of a read with MEM_LAT=3. Expect no done0 or done1, all outputs 0 the next cycle, and a subsequent tie to grant master 0.
- Field change after latch: change addr0 and wdata0 during WAIT. Expect memory to see only the values latched in IDLE.
